// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and width helpers for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SEND   = 2'd2
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request above the pointer, wrapping
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter among NUM_REQ byte sources
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ       = 4,
    parameter int  DATA_WIDTH    = 8,
    parameter int  START_TIMEOUT = 16384,
    localparam int ID_W          = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          busy,
    output logic                          tx_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [ID_W-1:0]               grant_id,
    output logic                          active,
    output logic                          frame_done,
    output logic                          timeout_err
);

    localparam int               CNT_W    = cnt_width(START_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    arb_state_t         state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [CNT_W-1:0]   wait_cnt;
    logic               grant_ok;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (win_onehot),
        .grant_idx (win_idx)
    );

    // Holding off during the completion pulse guarantees an idle clock between frames.
    assign grant_ok  = rst && (state == IDLE) && enable && !busy && !frame_done && !timeout_err;
    assign req_ready = grant_ok ? win_onehot : '0;
    assign accept    = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            wait_cnt    <= '0;
            tx_en       <= 1'b0;
            active      <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            data_in     <= '0;
            grant_id    <= '0;
        end else begin
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        data_in  <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        grant_id <= win_idx;
                        tx_en    <= 1'b1;
                        active   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (busy) begin
                        tx_en <= 1'b0;
                        state <= SEND;
                    end else if (wait_cnt == CNT_LAST) begin
                        tx_en       <= 1'b0;
                        active      <= 1'b0;
                        timeout_err <= 1'b1;
                        ptr         <= grant_id;
                        state       <= IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                SEND: begin
                    tx_en <= 1'b0;
                    if (!busy) begin
                        frame_done <= 1'b1;
                        active     <= 1'b0;
                        ptr        <= grant_id;
                        state      <= IDLE;
                    end
                end
                default: begin
                    tx_en  <= 1'b0;
                    active <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a small UART transmitter model
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int ST = 16;
    localparam int BP = 4;
    localparam int TX_DLY = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_ready;
    logic           busy;
    logic           tx_en;
    logic [DW-1:0]  data_in;
    logic [1:0]     grant_id;
    logic           active;
    logic           frame_done;
    logic           timeout_err;

    logic           busy_man = 1'b0;
    logic           model_on = 1'b0;
    logic           busy_m = 1'b0;
    logic           txd = 1'b1;

    int total = 0;
    int bad = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .DATA_WIDTH    (DW),
        .START_TIMEOUT (ST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .busy        (busy),
        .tx_en       (tx_en),
        .data_in     (data_in),
        .grant_id    (grant_id),
        .active      (active),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    assign busy = model_on ? busy_m : busy_man;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy rises so that tx_en is seen high for TX_DLY cycles, then 10 bits of BP clocks.
    int         wcnt = 0;
    int         bcnt = 0;
    int         bidx = 0;
    logic [9:0] fv = 10'h3ff;

    always @(posedge clk) begin
        if (!model_on) begin
            busy_m <= 1'b0;
            wcnt   <= 0;
            txd    <= 1'b1;
        end else if (!busy_m) begin
            if (tx_en) begin
                if (wcnt == TX_DLY - 2) begin
                    busy_m <= 1'b1;
                    wcnt   <= 0;
                    fv     <= {1'b1, data_in, 1'b0};
                    bidx   <= 0;
                    bcnt   <= 0;
                    txd    <= 1'b0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else begin
                wcnt <= 0;
            end
        end else if (bcnt == BP - 1) begin
            bcnt <= 0;
            if (bidx == 9) begin
                busy_m <= 1'b0;
                txd    <= 1'b1;
            end else begin
                bidx <= bidx + 1;
                txd  <= fv[bidx+1];
            end
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    logic [7:0] exp_rx[$];
    logic [7:0] rx_byte;
    logic [7:0] rx_exp;

    initial forever begin
        @(negedge txd);
        repeat (2) @(posedge clk);
        rx_byte = '0;
        for (int i = 0; i < 8; i++) begin
            repeat (BP) @(posedge clk);
            rx_byte[i] = txd;
        end
        repeat (BP) @(posedge clk);
        check("rx_stop_bit", 32'(txd), 32'd1);
        if (exp_rx.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got byte %0h expected none", rx_byte);
        end else begin
            rx_exp = exp_rx.pop_front();
            check("rx_byte", 32'(rx_byte), 32'(rx_exp));
        end
    end

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int   n_acc = 0, n_txen = 0, n_rdy = 0, n_done = 0, n_to = 0, n_viol = 0, n_unstable = 0;
    logic chk_pend = 1'b0;
    logic busy_prev = 1'b0;
    logic [7:0] held = '0;

    always @(negedge clk) begin
        if (!rst) begin
            chk_pend = 1'b0;
        end else begin
            if (chk_pend) begin
                chk_pend = 1'b0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL accept_unexpected: got grant_id=%0d expected no accept", grant_id);
                end else begin
                    e = sb.pop_front();
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("data_in", 32'(data_in), 32'(e.data));
                end
            end
            if (|(req_valid & req_ready)) begin
                chk_pend = 1'b1;
                n_acc++;
            end
            if (tx_en) n_txen++;
            if (|req_ready) n_rdy++;
            if (frame_done) n_done++;
            if (timeout_err) n_to++;
            if ((frame_done && timeout_err) || ((frame_done || timeout_err) && |req_ready)) n_viol++;
            if (model_on) begin
                if (busy && !busy_prev) held = data_in;
                else if (busy && data_in != held) n_unstable++;
                busy_prev = busy;
            end
        end
    end

    typedef struct {
        logic [3:0] valid;
        logic       en;
        logic       bsy;
        logic [3:0] ready;
    } vec_t;

    vec_t vt[8];

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        enable = 1'b1;
        busy_man = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int b_acc, b_tx, b_rdy, b_done, b_to;

    initial begin
        vt[0] = '{4'b0001, 1'b1, 1'b0, 4'b0001};
        vt[1] = '{4'b0110, 1'b1, 1'b0, 4'b0010};
        vt[2] = '{4'b1000, 1'b1, 1'b0, 4'b1000};
        vt[3] = '{4'b1111, 1'b1, 1'b0, 4'b0001};
        vt[4] = '{4'b1100, 1'b1, 1'b0, 4'b0100};
        vt[5] = '{4'b1111, 1'b0, 1'b0, 4'b0000};
        vt[6] = '{4'b1111, 1'b1, 1'b1, 4'b0000};
        vt[7] = '{4'b0000, 1'b1, 1'b0, 4'b0000};
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset state, with requests pending while reset is held
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b1111;
        #1;
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Priority vectors from the reset pointer, applied between edges
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #2;
            req_valid = vt[k].valid;
            enable = vt[k].en;
            busy_man = vt[k].bsy;
            #1;
            check($sformatf("vec%0d_req_ready", k), 32'(req_ready), 32'(vt[k].ready));
            #1;
            req_valid = '0;
            enable = 1'b1;
            busy_man = 1'b0;
        end

        // Single request through the transmitter model
        do_reset();
        model_on = 1'b1;
        req_data[2*DW +: DW] = 8'hA5;
        b_acc = n_acc; b_tx = n_txen; b_rdy = n_rdy; b_done = n_done;
        sb.push_back('{2'd2, 8'hA5});
        exp_rx.push_back(8'hA5);
        req_valid = 4'b0100;
        for (int i = 0; i < 20 && n_acc == b_acc; i++) tick();
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int i = 0; i < 100 && n_done == b_done; i++) tick();
        repeat (4) tick();
        check("single_tx_en_cycles", 32'(n_txen - b_tx), 32'd5);
        check("single_ready_cycles", 32'(n_rdy - b_rdy), 32'd1);
        check("single_frame_done", 32'(n_done - b_done), 32'd1);
        check("single_active_end", 32'(active), 32'd0);
        check("single_rx_drained", 32'(exp_rx.size()), 32'd0);

        // Round robin with all requesters valid for 8 frames
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        b_acc = n_acc; b_done = n_done;
        for (int k = 0; k < 8; k++) begin
            sb.push_back('{2'(k % 4), 8'(8'h11 * (k % 4 + 1))});
            exp_rx.push_back(8'(8'h11 * (k % 4 + 1)));
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 1000 && n_acc < b_acc + 8; i++) tick();
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int i = 0; i < 200 && n_done < b_done + 8; i++) tick();
        repeat (4) tick();
        check("rr_frames", 32'(n_done - b_done), 32'd8);
        check("rr_sb_drained", 32'(sb.size()), 32'd0);
        check("rr_rx_drained", 32'(exp_rx.size()), 32'd0);

        // Start timeout with busy held low
        model_on = 1'b0;
        do_reset();
        req_data[1*DW +: DW] = 8'h3C;
        b_acc = n_acc; b_tx = n_txen; b_done = n_done; b_to = n_to;
        sb.push_back('{2'd1, 8'h3C});
        req_valid = 4'b0010;
        for (int i = 0; i < 20 && n_acc == b_acc; i++) tick();
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int i = 0; i < 40 && n_to == b_to; i++) tick();
        repeat (3) tick();
        check("to_tx_en_cycles", 32'(n_txen - b_tx), 32'd16);
        check("to_pulses", 32'(n_to - b_to), 32'd1);
        check("to_no_frame_done", 32'(n_done - b_done), 32'd0);
        check("to_active_end", 32'(active), 32'd0);
        @(negedge clk);
        #2;
        req_valid = 4'b1111;
        #1;
        check("to_pointer_advanced", 32'(req_ready), 32'b0100);
        #1;
        req_valid = '0;

        // Reset in the middle of LAUNCH, then requester 0 wins first
        do_reset();
        b_acc = n_acc;
        sb.push_back('{2'd0, 8'h11});
        req_valid = 4'b0001;
        for (int i = 0; i < 20 && n_acc == b_acc; i++) tick();
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) tick();
        check("launch_tx_en_before_rst", 32'(tx_en), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_tx_en", 32'(tx_en), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        sb.push_back('{2'd0, 8'h11});
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("postrst_winner", 32'(req_ready), 32'b0001);
        b_acc = n_acc; b_to = n_to;
        for (int i = 0; i < 20 && n_acc == b_acc; i++) tick();
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int i = 0; i < 40 && n_to == b_to; i++) tick();
        repeat (2) tick();

        // Busy collision and enable gating
        do_reset();
        b_rdy = n_rdy; b_done = n_done; b_acc = n_acc;
        busy_man = 1'b1;
        req_valid = 4'b0001;
        repeat (4) tick();
        check("busy_idle_no_ready", 32'(n_rdy - b_rdy), 32'd0);
        busy_man = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        check("disabled_no_ready", 32'(n_rdy - b_rdy), 32'd0);
        sb.push_back('{2'd0, 8'h11});
        @(posedge clk);
        #1;
        enable = 1'b1;
        #1;
        check("enable_ready", 32'(req_ready), 32'b0001);
        for (int i = 0; i < 20 && n_acc == b_acc; i++) tick();
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (2) tick();
        busy_man = 1'b1;
        repeat (2) tick();
        enable = 1'b0;
        repeat (5) tick();
        busy_man = 1'b0;
        for (int i = 0; i < 10 && n_done == b_done; i++) tick();
        repeat (2) tick();
        check("send_completes_disabled", 32'(n_done - b_done), 32'd1);
        check("send_active_end", 32'(active), 32'd0);
        enable = 1'b1;

        // Two requesters onto the serial line
        do_reset();
        model_on = 1'b1;
        req_data[1*DW +: DW] = 8'hC3;
        req_data[3*DW +: DW] = 8'h5A;
        b_acc = n_acc; b_done = n_done;
        sb.push_back('{2'd1, 8'hC3});
        sb.push_back('{2'd3, 8'h5A});
        exp_rx.push_back(8'hC3);
        exp_rx.push_back(8'h5A);
        req_valid = 4'b1010;
        for (int k = 1; k <= 2; k++) begin
            for (int i = 0; i < 200 && n_acc < b_acc + k; i++) tick();
            @(posedge clk);
            #1;
            req_valid[grant_id] = 1'b0;
        end
        for (int i = 0; i < 200 && n_done < b_done + 2; i++) tick();
        repeat (4) tick();
        check("int_frames", 32'(n_done - b_done), 32'd2);
        check("int_rx_drained", 32'(exp_rx.size()), 32'd0);
        check("int_sb_drained", 32'(sb.size()), 32'd0);
        check("int_data_stable", 32'(n_unstable), 32'd0);
        check("pulse_exclusive", 32'(n_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
